// File: rtl/ahb_ui_write_feeder.sv
// ahb_ui_write_feeder
//   Upstream stage of ahb_master. Turns a write-command stream and a write-data
//   stream into the master's user interface, advancing only when i_next=1.
//   Write data is buffered in an internal FIFO. When the FIFO is empty, the
//   block presents dav=0 bubble beats. This block never issues reads.
//
// Optional feature macro: AHB_UI_FEEDER_MERGE_EN
//   When defined, a command that continues exactly where the current burst
//   ends (same size, address == next_addr) is merged into the running burst.
//
// Ports
//   i_hclk, i_hreset           clock, synchronous active-high reset
//   i_cmd_*/o_cmd_ready        command stream (addr, len in beats, hsize)
//   i_wdata_*/o_wdata_ready    write-data stream into the FIFO
//   i_next                     master o_next; UI outputs update only when 1
//   o_data/o_dav/o_addr/o_size/o_wr/o_rd/o_min_len/o_cont   master UI
//   o_busy                     FSM not idle
//   o_level                    FIFO occupancy
module ahb_ui_write_feeder #(
  parameter int DATA_WDT = 32,
  parameter int BEAT_WDT = 32,
  parameter int DEPTH    = 16
) (
  input  logic                       i_hclk,
  input  logic                       i_hreset,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic [31:0]                i_cmd_addr,
  input  logic [BEAT_WDT-1:0]        i_cmd_len,
  input  logic [2:0]                 i_cmd_size,
  input  logic                       i_wdata_valid,
  output logic                       o_wdata_ready,
  input  logic [DATA_WDT-1:0]        i_wdata,
  input  logic                       i_next,
  output logic [DATA_WDT-1:0]        o_data,
  output logic                       o_dav,
  output logic [31:0]                o_addr,
  output logic [2:0]                 o_size,
  output logic                       o_wr,
  output logic                       o_rd,
  output logic [BEAT_WDT-1:0]        o_min_len,
  output logic                       o_cont,
  output logic                       o_busy,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_STREAM} state_t;

  // ---------------- write-data FIFO ----------------
  logic [DATA_WDT-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wptr_q, rptr_q;
  logic [LW-1:0]       level_q;
  logic                push, pop, avail;
  logic [DATA_WDT-1:0] head;

  assign o_wdata_ready = (level_q != LW'(DEPTH));
  assign push          = i_wdata_valid & o_wdata_ready;
  assign avail         = (level_q != '0);
  // Never-written slots would read as X; present zero while empty instead.
  assign head          = avail ? mem_q[rptr_q] : '0;

  always_ff @(posedge i_hclk) begin
    if (push) mem_q[wptr_q] <= i_wdata;
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end

  // ---------------- command / UI FSM ----------------
  state_t              state_q, state_d;
  logic [31:0]         lat_addr_q, lat_addr_d;
  logic [BEAT_WDT-1:0] lat_len_q, lat_len_d;
  logic [2:0]          lat_size_q, lat_size_d;
  logic [BEAT_WDT-1:0] rem_q, rem_d;
  logic [31:0]         next_addr_q, next_addr_d;
  logic [DATA_WDT-1:0] data_q, data_d;
  logic                dav_q, dav_d;
  logic [31:0]         addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic                wr_q, wr_d;
  logic [BEAT_WDT-1:0] min_len_q, min_len_d;
  logic                cont_q, cont_d;
  logic                merge_ok;

  function automatic logic [31:0] beat_step(input logic [2:0] sz, input logic en);
    return en ? (32'd1 << sz) : 32'd0;
  endfunction

  always_comb begin
    state_d     = state_q;
    lat_addr_d  = lat_addr_q;
    lat_len_d   = lat_len_q;
    lat_size_d  = lat_size_q;
    rem_d       = rem_q;
    next_addr_d = next_addr_q;
    data_d      = data_q;
    dav_d       = dav_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wr_d        = wr_q;
    min_len_d   = min_len_q;
    cont_d      = cont_q;
    pop         = 1'b0;
    o_cmd_ready = 1'b0;
`ifdef AHB_UI_FEEDER_MERGE_EN
    merge_ok    = i_cmd_valid && (i_cmd_len != '0) &&
                  (i_cmd_addr == next_addr_q) && (i_cmd_size == size_q);
`else
    merge_ok    = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid && (i_cmd_len != '0)) begin
          lat_addr_d = i_cmd_addr;
          lat_len_d  = i_cmd_len;
          lat_size_d = i_cmd_size;
          state_d    = S_ARM;
        end
      end
      S_ARM: begin
        if (i_next) begin
          wr_d        = 1'b1;
          cont_d      = 1'b0;
          addr_d      = lat_addr_q;
          size_d      = lat_size_q;
          min_len_d   = lat_len_q;
          dav_d       = avail;
          data_d      = head;
          pop         = avail;
          rem_d       = lat_len_q - BEAT_WDT'(avail);
          next_addr_d = lat_addr_q + beat_step(lat_size_q, avail);
          state_d     = S_STREAM;
        end
      end
      S_STREAM: begin
        if (i_next) begin
          if (rem_q != '0) begin
            cont_d      = 1'b1;
            dav_d       = avail;
            data_d      = head;
            pop         = avail;
            rem_d       = rem_q - BEAT_WDT'(avail);
            next_addr_d = next_addr_q + beat_step(size_q, avail);
          end else if (merge_ok) begin
            // Contiguous follow-on command: extend the burst without dropping o_wr.
            o_cmd_ready = 1'b1;
            wr_d        = 1'b1;
            cont_d      = 1'b1;
            min_len_d   = i_cmd_len;
            dav_d       = avail;
            data_d      = head;
            pop         = avail;
            rem_d       = i_cmd_len - BEAT_WDT'(avail);
            next_addr_d = next_addr_q + beat_step(size_q, avail);
          end else begin
            wr_d    = 1'b0;
            dav_d   = 1'b0;
            cont_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      state_q     <= S_IDLE;
      lat_addr_q  <= '0;
      lat_len_q   <= '0;
      lat_size_q  <= '0;
      rem_q       <= '0;
      next_addr_q <= '0;
      data_q      <= '0;
      dav_q       <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      wr_q        <= 1'b0;
      min_len_q   <= '0;
      cont_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_addr_q  <= lat_addr_d;
      lat_len_q   <= lat_len_d;
      lat_size_q  <= lat_size_d;
      rem_q       <= rem_d;
      next_addr_q <= next_addr_d;
      data_q      <= data_d;
      dav_q       <= dav_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wr_q        <= wr_d;
      min_len_q   <= min_len_d;
      cont_q      <= cont_d;
    end
  end

  assign o_data    = data_q;
  assign o_dav     = dav_q;
  assign o_addr    = addr_q;
  assign o_size    = size_q;
  assign o_wr      = wr_q;
  assign o_rd      = 1'b0;
  assign o_min_len = min_len_q;
  assign o_cont    = cont_q;
  assign o_busy    = (state_q != S_IDLE);
  assign o_level   = level_q;

endmodule
